// File: rtl/opc2_pkg.sv
// Shared definitions for the OPC2 bus responder: bus widths, boot vector,
// I/O port address and the responder state encoding.
package opc2_pkg;

    localparam int unsigned OPC2_ADDR_W = 10;
    localparam int unsigned OPC2_DATA_W = 8;

    localparam logic [OPC2_ADDR_W-1:0] OPC2_RESET_VEC = 10'h100;
    localparam logic [OPC2_ADDR_W-1:0] OPC2_IO_ADDR   = 10'h3FF;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } opc2_state_e;

endpackage

// File: rtl/opc2_ram.sv
// Program/data store: asynchronous read port, single synchronous write port.
// Contents have no reset so a responder reset never clears the image.
module opc2_ram
    import opc2_pkg::*;
#(
    parameter int unsigned ADDR_W = OPC2_ADDR_W,
    parameter int unsigned DATA_W = OPC2_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/opc2_bus_responder.sv
// OPC2 memory-side responder: boots a byte-stream image into RAM while holding
// the CPU in reset, then serves CPU bus cycles. OPC2_RESP_IO_EN adds an output port at 10'h3FF.
module opc2_bus_responder
    import opc2_pkg::*;
#(
    parameter int unsigned       ADDR_W    = OPC2_ADDR_W,
    parameter int unsigned       DATA_W    = OPC2_DATA_W,
    parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'(OPC2_RESET_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rnw,
    inout  wire  [DATA_W-1:0] data,
    output logic              cpu_reset_b,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready
`ifdef OPC2_RESP_IO_EN
    ,
    output logic [DATA_W-1:0] io_data,
    output logic              io_strobe
`endif
);

    localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(OPC2_IO_ADDR);

    opc2_state_e       state;
    opc2_state_e       state_next;
    logic [ADDR_W-1:0] ptr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_data;
    logic              bus_drive;
    logic              io_wr;
    logic              load_fire;

    assign load_fire = load_valid && (state == ST_LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave LOAD on the accepted final image byte; RUN exits only via reset
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (load_fire && load_last) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_LOAD;
        endcase
    end

    // Output decode: steer the single RAM write port between loader and CPU
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr;
        ram_wdata = load_data;
        bus_drive = 1'b0;
        io_wr     = 1'b0;
        case (state)
            ST_LOAD: begin
                ram_we = load_valid;
            end
            ST_RUN: begin
                ram_waddr = address;
                ram_wdata = data;
                if (rnw) begin
                    bus_drive = 1'b1;
                end else begin
`ifdef OPC2_RESP_IO_EN
                    io_wr = (address == IO_ADDR);
`endif
                    ram_we = !io_wr;
                end
            end
            default: ;
        endcase
    end

    // Handshake/reset outputs come straight from flops so cpu_reset_b cannot glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset_b <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            cpu_reset_b <= (state_next == ST_RUN);
            load_ready  <= (state_next == ST_LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= LOAD_BASE;
        end else if (load_fire) begin
            ptr <= ADDR_W'(ptr + 1'b1);
        end
    end

`ifdef OPC2_RESP_IO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            io_data   <= '0;
            io_strobe <= 1'b0;
        end else begin
            io_strobe <= io_wr;
            if (io_wr) begin
                io_data <= data;
            end
        end
    end

    assign rd_data = (address == IO_ADDR) ? io_data : ram_rdata;
`else
    assign rd_data = ram_rdata;
`endif

    assign data = bus_drive ? rd_data : {DATA_W{1'bz}};

    opc2_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(address),
        .rdata(ram_rdata)
    );

endmodule
